// File: rtl/apb_wait_slave.sv
// APB4 completer fronting a DEPTH-word register memory, with byte-lane strobes,
// a fixed number of wait states per access and PSLVERR on bad addresses.
module apb_wait_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = (NB > 1) ? $clog2(NB) : 0;
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'((1 << LSB) - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              cnt;
    logic                    setup_go, complete, cnt_inc, ready;
    logic                    wr_q, err_q;
    logic [IW-1:0]           idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NB-1:0]           strb_q;
    logic [DATA_WIDTH-1:0]   prdata_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        word_idx = IW'(a >> LSB);
    endfunction

    // Misaligned byte address or a word index past the end of the memory.
    function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] idx;
        idx = a >> LSB;
        addr_bad = ((a & LANE_MASK) != '0) || (32'(idx) >= DEPTH);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]         strb
    );
        for (int i = 0; i < NB; i++)
            merge_lanes[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    endfunction

    assign ready   = (state == ACCESS) && (cnt == WS);
    assign PREADY  = ready;
    assign PSLVERR = ready & err_q;
    assign PRDATA  = prdata_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        setup_go  = 1'b0;
        complete  = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                // A lone PENABLE without a setup cycle is not a transfer.
                if (PSEL && !PENABLE) begin
                    state_nxt = ACCESS;
                    setup_go  = 1'b1;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_nxt = IDLE;
                end else if (PENABLE && ready) begin
                    state_nxt = IDLE;
                    complete  = 1'b1;
                end else if (!ready) begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Setup stage: capture the request; access stage: count waits and commit writes.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt      <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            prdata_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (setup_go) begin
                cnt     <= '0;
                wr_q    <= PWRITE;
                err_q   <= addr_bad(PADDR);
                idx_q   <= word_idx(PADDR);
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
                if (!PWRITE)
                    prdata_q <= addr_bad(PADDR) ? '0 : mem[word_idx(PADDR)];
            end else if (cnt_inc) begin
                cnt <= cnt + 4'd1;
            end
            if (complete && wr_q && !err_q)
                mem[idx_q] <= merge_lanes(mem[idx_q], wdata_q, strb_q);
        end
    end

endmodule

// File: tb/tb_apb_wait_slave.sv
// Directed bench for apb_wait_slave: one instance with no wait states and one with three,
// driven from a shared bus whose PSEL is steered to the selected instance.
module tb_apb_wait_slave;

    logic        clk = 1'b0;
    logic        presetn;
    logic        psel, penable, pwrite, which;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata0, prdata3, prdata;
    logic        pready0, pready3, pready;
    logic        pslverr0, pslverr3, pslverr;
    logic        psel0, psel3;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    assign psel0   = psel & ~which;
    assign psel3   = psel & which;
    assign prdata  = which ? prdata3  : prdata0;
    assign pready  = which ? pready3  : pready0;
    assign pslverr = which ? pslverr3 : pslverr0;

    apb_wait_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) u_dut0 (
        .PCLK(clk), .PRESETn(presetn), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
    );

    apb_wait_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) u_dut3 (
        .PCLK(clk), .PRESETn(presetn), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
    );

    typedef struct {
        logic        dut;
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        chk_rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_waits;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Entered and left at posedge+1; leaves PSEL/PENABLE high so a following call is back-to-back.
    task automatic apb_xfer(input logic d, input logic wr, input logic [11:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            output logic [31:0] rdata, output logic err, output int waits);
        which = d; psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = data; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        while (!pready && waits < 40) begin
            waits++;
            @(posedge clk); #1;
        end
        rdata = prdata;
        err   = pslverr;
        @(posedge clk); #1;
    endtask

    task automatic go_idle(input int n);
        psel = 1'b0; penable = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          wt;

        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; which = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;

        //            dut  wr    addr      wdata         strb    chk  rdata         err  waits
        vecs.push_back('{1'b0, 1'b1, 12'h004, 32'hA5A5A5A5, 4'b1111, 1'b0, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 12'h004, 32'h0,        4'b0000, 1'b1, 32'hA5A5A5A5, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b1, 12'h004, 32'h11223344, 4'b0101, 1'b0, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 12'h004, 32'h0,        4'b0000, 1'b1, 32'hA522A544, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b1, 12'h102, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0,        1'b1, 0});
        vecs.push_back('{1'b0, 1'b1, 12'h100, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0,        1'b1, 0});
        vecs.push_back('{1'b0, 1'b1, 12'h006, 32'hDEADBEEF, 4'b1111, 1'b0, 32'h0,        1'b1, 0});
        vecs.push_back('{1'b0, 1'b0, 12'h100, 32'h0,        4'b0000, 1'b1, 32'h0,        1'b1, 0});
        vecs.push_back('{1'b0, 1'b0, 12'h004, 32'h0,        4'b0000, 1'b1, 32'hA522A544, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 12'h000, 32'h0,        4'b0000, 1'b1, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 1'b1, 12'h0FC, 32'hCAFEF00D, 4'b1111, 1'b0, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 12'h0FC, 32'h0,        4'b0000, 1'b1, 32'hCAFEF00D, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b1, 12'h008, 32'h12345678, 4'b0000, 1'b0, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 12'h008, 32'h0,        4'b0000, 1'b1, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b1, 1'b1, 12'h008, 32'h55AA55AA, 4'b1111, 1'b0, 32'h0,        1'b0, 3});
        vecs.push_back('{1'b1, 1'b0, 12'h100, 32'h0,        4'b0000, 1'b1, 32'h0,        1'b1, 3});
        vecs.push_back('{1'b1, 1'b0, 12'h008, 32'h0,        4'b0000, 1'b1, 32'h55AA55AA, 1'b0, 3});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_prdata0", prdata0, 32'h0);
        chk("rst_pready0", {31'h0, pready0}, 32'h0);
        chk("rst_pslverr0", {31'h0, pslverr0}, 32'h0);
        chk("rst_pready3", {31'h0, pready3}, 32'h0);
        presetn = 1'b1;
        @(posedge clk); #1;

        // PENABLE raised with no setup cycle must not start a transfer.
        psel = 1'b1; penable = 1'b1; which = 1'b0; pwrite = 1'b1; paddr = 12'h004;
        pwdata = 32'hFFFFFFFF; pstrb = 4'b1111;
        @(posedge clk); #1;
        chk("no_setup_pready_a", {31'h0, pready}, 32'h0);
        @(posedge clk); #1;
        chk("no_setup_pready_b", {31'h0, pready}, 32'h0);
        go_idle(1);

        foreach (vecs[i]) begin
            apb_xfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, wt);
            chk($sformatf("v%0d_waits", i), 32'(wt), 32'(vecs[i].exp_waits));
            chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
            if (vecs[i].chk_rd)
                chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
        end
        go_idle(1);

        // Abort: PSEL dropped in the second ACCESS cycle of a write to 0x008.
        which = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h008; pwdata = 32'hFFFFFFFF; pstrb = 4'b1111;
        @(posedge clk); #1;
        penable = 1'b1;
        chk("abort_acc1_pready", {31'h0, pready}, 32'h0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        chk("abort_acc2_pready", {31'h0, pready}, 32'h0);
        chk("abort_acc2_pslverr", {31'h0, pslverr}, 32'h0);
        @(posedge clk); #1;
        chk("abort_idle_pready", {31'h0, pready}, 32'h0);
        apb_xfer(1'b1, 1'b0, 12'h008, 32'h0, 4'b0000, rd, er, wt);
        chk("abort_readback", rd, 32'h55AA55AA);
        go_idle(1);

        // Reset pulse in the middle of a write to 0x00C.
        which = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h00C; pwdata = 32'h12345678; pstrb = 4'b1111;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        presetn = 1'b0;
        #2;
        chk("midrst_prdata", prdata3, 32'h0);
        chk("midrst_pready", {31'h0, pready3}, 32'h0);
        chk("midrst_pslverr", {31'h0, pslverr3}, 32'h0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        presetn = 1'b1;
        @(posedge clk); #1;
        apb_xfer(1'b1, 1'b0, 12'h008, 32'h0, 4'b0000, rd, er, wt);
        chk("midrst_read_008", rd, 32'h0);
        apb_xfer(1'b1, 1'b0, 12'h00C, 32'h0, 4'b0000, rd, er, wt);
        chk("midrst_read_00C", rd, 32'h0);
        chk("midrst_read_waits", 32'(wt), 32'd3);
        apb_xfer(1'b0, 1'b0, 12'h004, 32'h0, 4'b0000, rd, er, wt);
        chk("midrst_read_dut0", rd, 32'h0);
        go_idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
